fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Its output is the opcode/funct stream that the decode-stage controller consumes.
- Holds the PC and issues requests to instruction memory over a req/ready handshake, so both single-cycle ROM and variable-latency memory are supported.
- Registers each fetched word into the IF/ID pipeline register.
- Handles decode-stage stall, taken beq and j redirects (no delay slot), and buffers a returned word while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width (fixed at 32; parameter for documentation only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals the internal PC.
- imem_rdata  in  32  instruction word; valid only when imem_ready=1.
- imem_ready  in  1  completes the request in the same cycle; may be high in the request cycle.
- stallD  in  1  decode stall from hazard unit; freezes PC and IF/ID.
- pcsrcD  in  1  beq taken in decode.
- pc_branchD  in  32  branch target.
- jumpD  in  1  j in decode.
- instrD  out  32  IF/ID instruction.
- pcplus4D  out  32  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction.
- opcodeD  out  6  instrD[31:26].
- functD  out  6  instrD[5:0].

Behaviour:
- Reset (synchronous):
  - pc = RESET_PC; state = FETCH.
  - instrD = 0, pcplus4D = 0, validD = 0 (bubble, encodes sll $0 = nop).
  - imem_req = 0 during the reset cycle; pending redirect cleared; skid buffer invalid.
  - Reset mid-transaction abandons any outstanding request; a late imem_ready after reset is ignored until a new req is issued.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; the returned word sits in the skid buffer.
  - DRAIN: imem_req=1 at the old address; a redirect is pending.
- Address rule: imem_addr holds stable while imem_req=1 and imem_ready=0.
- Redirect is effective only when validD=1 and stallD=0.
  - Target: pcsrcD gives pc_branchD. jumpD gives {pcplus4D[31:28], instrD[25:0], 2'b00}.
  - pcsrcD has priority if both are asserted.
  - Redirect with stallD=1 is ignored that cycle.
- FETCH, imem_ready=1, no redirect:
  - stallD=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4. Throughput is 1 instruction/cycle with a same-cycle ready.
  - stallD=1: skid <= imem_rdata; IF/ID unchanged; go HOLD.
- FETCH, imem_ready=0, no redirect:
  - stallD=0: IF/ID <= bubble (validD=0).
  - stallD=1: IF/ID unchanged.
- FETCH, redirect, imem_ready=1: fetched word discarded; pc <= target; IF/ID <= bubble.
- FETCH, redirect, imem_ready=0: pending <= target; IF/ID <= bubble; go DRAIN.
- DRAIN: on imem_ready, data discarded; pc <= pending; go FETCH. IF/ID stays bubble while draining.
- HOLD:
  - While stallD=1: nothing changes.
  - When stallD=0: IF/ID <= {skid, pc+4, 1}; pc <= pc+4; go FETCH. A redirect cannot occur in HOLD because the stalled instruction is still in decode.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Bits [1:0] of targets pass through unchecked.
- opcodeD and functD are combinational slices of instrD. After reset they read 0, which is an R-type with funct 0.

Test Plan:
- Sequential fetch: rst, then 4 cycles with ROM ready=1 and words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 at 0,4,8,C. Required: instrD follows one cycle per fetch; pcplus4D = 4,8,C,10; validD=1 from cycle 2; opcodeD=0x08, 0x08, 0x00, 0x2B; functD=0x20 for the third word.
- Stall with skid: ready=1 at addr 8 while stallD=1 for 3 cycles. Required: imem_req drops and pc holds at 8. instrD holds the addr-4 word, then takes the addr-8 word the cycle after stallD falls, and fetch resumes at 0xC.
- Taken branch: instrD=beq at pc 0x10, pcsrcD=1, pc_branchD=0x40, stallD=0. Required: the word fetched from 0x14 is dropped; next-cycle validD=0, imem_addr=0x40, then the 0x40 word with pcplus4D=0x44.
- Jump into slow memory: jumpD=1, instrD=0x08000020, pcplus4D=0x10000008, outstanding req at 0x8 with ready delayed 3 cycles. Required: imem_addr stays 0x8 until ready; the data is discarded; next imem_addr=0x10000080; validD=0 throughout the drain.
- Redirect under stall plus wrap: pcsrcD=1 with stallD=1 gives no pc change. Separately, pc=0xFFFFFFFC with ready=1 gives pcplus4D=0 and next imem_addr=0.
- Reset mid-transaction: rst asserted during DRAIN, with late ready=1 the cycle after. Required: pc=RESET_PC, validD=0, the late data ignored, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ready instruction-memory
// handshake, and fills the IF/ID register, handling decode stalls and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stallD,
  input  logic            pcsrcD,
  input  logic [XLEN-1:0] pc_branchD,
  input  logic            jumpD,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD,
  output logic [5:0]      opcodeD,
  output logic [5:0]      functD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic [XLEN-1:0] pending_q, pending_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect;

  assign pc_plus4     = pc_q + 32'd4;
  assign jump_tgt     = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
  assign redirect_tgt = pcsrcD ? pc_branchD : jump_tgt;
  // A branch/jump only counts once the decode slot holds a real, non-stalled instruction.
  assign redirect     = valid_q && !stallD && (pcsrcD || jumpD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      skid_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      skid_q    <= skid_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          if (!imem_ready) state_d = S_DRAIN;
        end else if (imem_ready && stallD) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (!stallD)    state_d = S_FETCH;
      S_DRAIN: if (imem_ready) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    pending_d = pending_q;
    imem_req  = !rst && (state_q != S_HOLD);
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          instr_d   = '0;
          pcplus4_d = '0;
          valid_d   = 1'b0;
          if (imem_ready) pc_d = redirect_tgt;
          else            pending_d = redirect_tgt;
        end else if (imem_ready) begin
          if (!stallD) begin
            instr_d   = imem_rdata;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            skid_d = imem_rdata;
          end
        end else if (!stallD) begin
          instr_d   = '0;
          pcplus4_d = '0;
          valid_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stallD) begin
          instr_d   = skid_q;
          pcplus4_d = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
        end
      end
      S_DRAIN: begin
        // The in-flight word belongs to the abandoned path; drop it and retarget.
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
        if (imem_ready) pc_d = pending_q;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign instrD    = instr_q;
  assign pcplus4D  = pcplus4_q;
  assign validD    = valid_q;
  assign opcodeD   = instr_q[31:26];
  assign functD    = instr_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        stallD = 1'b0;
  logic        pcsrcD = 1'b0;
  logic [31:0] pc_branchD = '0;
  logic        jumpD = 1'b0;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic [5:0]  opcodeD;
  logic [5:0]  functD;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view of fetch plus one-entry queues for
  // the buffered word and the pending redirect target.
  logic [31:0] m_pc, m_instr, m_pp4;
  bit          m_valid;
  logic [31:0] skid_q[$];
  logic [31:0] pend_q[$];

  fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .stallD(stallD), .pcsrcD(pcsrcD),
    .pc_branchD(pc_branchD), .jumpD(jumpD), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .opcodeD(opcodeD), .functD(functD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      32'h0000_0008: return 32'h0109_5020;
      32'h0000_000C: return 32'hAC0A_0000;
      32'h1000_0004: return 32'h0800_0020;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] pp4);
    m_instr = w; m_pp4 = pp4; m_valid = 1'b1;
  endtask

  task automatic bubble();
    m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit rdy, input bit pcs,
                            input bit jmp, input logic [31:0] br, input logic [31:0] data);
    bit          redir;
    logic [31:0] tgt;
    redir = m_valid && !st && (pcs || jmp);
    tgt   = pcs ? br : {m_pp4[31:28], m_instr[25:0], 2'b00};
    if (r) begin
      m_pc = RESET_PC; bubble(); skid_q.delete(); pend_q.delete();
    end else if (skid_q.size() != 0) begin
      if (!st) begin deliver(skid_q.pop_front(), m_pc + 32'd4); m_pc = m_pc + 32'd4; end
    end else if (pend_q.size() != 0) begin
      bubble();
      if (rdy) m_pc = pend_q.pop_front();
    end else if (redir) begin
      bubble();
      if (rdy) m_pc = tgt; else pend_q.push_back(tgt);
    end else if (rdy) begin
      if (!st) begin deliver(data, m_pc + 32'd4); m_pc = m_pc + 32'd4; end
      else skid_q.push_back(data);
    end else if (!st) begin
      bubble();
    end
  endtask

  task automatic check_all();
    chk("validD", 32'(validD), 32'(m_valid));
    chk("imem_req", 32'(imem_req), 32'(!rst && skid_q.size() == 0));
    chk("imem_addr", imem_addr, m_pc);
    if (m_valid) begin
      chk("instrD", instrD, m_instr);
      chk("pcplus4D", pcplus4D, m_pp4);
      chk("opcodeD", 32'(opcodeD), 32'(m_instr[31:26]));
      chk("functD", 32'(functD), 32'(m_instr[5:0]));
    end
  endtask

  task automatic cycle(input bit r, input bit st, input bit rdy, input bit pcs,
                       input bit jmp, input logic [31:0] br);
    logic [31:0] data;
    data       = (rdy && !r) ? word_at(m_pc) : $urandom;
    rst        = r;
    stallD     = st;
    imem_ready = rdy;
    pcsrcD     = pcs;
    jumpD      = jmp;
    pc_branchD = br;
    imem_rdata = data;
    model_step(r, st, rdy, pcs, jmp, br, data);
    @(posedge clk);
    #1;
    check_all();
    $display("cyc rst=%0b stall=%0b rdy=%0b br=%0b j=%0b -> req=%0b addr=%h valid=%0b instrD=%h pp4=%h",
             r, st, rdy, pcs, jmp, imem_req, imem_addr, validD, instrD, pcplus4D);
  endtask

  initial begin
    bit st, rdy, pcs, jmp, r;
    logic [31:0] br;
    m_pc = RESET_PC; m_instr = '0; m_pp4 = '0; m_valid = 1'b0;

    // Reset
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    chk("rst_opcode", 32'(opcodeD), 32'h0);
    chk("rst_funct", 32'(functD), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    // Sequential fetch then skid under stall at address 8
    cycle(0, 0, 1, 0, 0, 0);
    chk("seq0_opcode", 32'(opcodeD), 32'h08);
    cycle(0, 0, 1, 0, 0, 0);
    chk("seq1_pp4", pcplus4D, 32'h8);
    cycle(0, 1, 1, 0, 0, 0);
    chk("stall_req", 32'(imem_req), 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("stall_hold_instr", instrD, 32'h2009_0003);
    cycle(0, 0, 0, 0, 0, 0);
    chk("skid_instr", instrD, 32'h0109_5020);
    chk("skid_funct", 32'(functD), 32'h20);
    chk("skid_resume_addr", imem_addr, 32'hC);
    cycle(0, 0, 1, 0, 0, 0);
    chk("seq3_opcode", 32'(opcodeD), 32'h2B);
    chk("seq3_pp4", pcplus4D, 32'h10);

    // Taken branch from 0x10 to 0x40
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 32'h40);
    chk("br_valid", 32'(validD), 32'h0);
    chk("br_addr", imem_addr, 32'h40);
    cycle(0, 0, 1, 0, 0, 0);
    chk("br_pp4", pcplus4D, 32'h44);

    // Jump while memory is slow
    cycle(0, 0, 1, 1, 0, 32'h1000_0004);
    cycle(0, 0, 1, 0, 0, 0);
    chk("j_setup_instr", instrD, 32'h0800_0020);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain_addr", imem_addr, 32'h1000_0008);
    chk("drain_valid", 32'(validD), 32'h0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("j_target", imem_addr, 32'h1000_0080);
    chk("j_valid", 32'(validD), 32'h0);
    cycle(0, 0, 1, 0, 0, 0);

    // Redirect ignored under stall, then wrap at the top of memory
    cycle(0, 1, 0, 1, 0, 32'h200);
    chk("stall_redirect_addr", imem_addr, 32'h1000_0084);
    cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("wrap_pp4", pcplus4D, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset during drain with a stale ready
    cycle(0, 0, 0, 1, 0, 32'h80);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_drain_addr", imem_addr, RESET_PC);
    chk("rst_drain_valid", 32'(validD), 32'h0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("rst_restart_instr", instrD, 32'h2008_0005);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      pcs = 1'b0;
      jmp = 1'b0;
      if (skid_q.size() == 0 || st) begin
        pcs = ($urandom_range(0, 7) == 0);
        jmp = ($urandom_range(0, 7) == 0);
      end
      br = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023)) << 2;
      cycle(r, st, rdy, pcs, jmp, br);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
